// File: rtl/bg_lsu_xbar_sched_pkg.sv
// Shared constants and types for the 4x4 BG/LSU crossbar scheduler.
package bg_lsu_xbar_sched_pkg;

    localparam int unsigned N_PORT = 4;
    localparam int unsigned SEL_W  = 2;
    localparam logic [N_PORT*SEL_W-1:0] SWITCH_IDENTITY = 8'hE4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bg_state_e;

endpackage

// File: rtl/bg_lsu_xbar_sched_if.sv
// Request/grant and crossbar-status bundle between the LSU request logic and the scheduler.
interface bg_lsu_xbar_sched_if
    import bg_lsu_xbar_sched_pkg::*;
#(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 16
) ();

    logic                      sched_en;
    logic [N_PORT-1:0]         lsu_req;
    logic [N_PORT*SEL_W-1:0]   lsu_bg;
    logic [N_PORT*LEN_W-1:0]   lsu_len;
    logic [N_PORT-1:0]         lsu_gnt;
    logic [N_PORT-1:0]         lsu_active;
    logic [N_PORT-1:0]         bg_active;
    logic [N_PORT*SEL_W-1:0]   bg_owner;
    logic [N_PORT*SEL_W-1:0]   switch;
    logic [CNT_W-1:0]          conflict_cnt;

    modport master (
        output sched_en, lsu_req, lsu_bg, lsu_len,
        input  lsu_gnt, lsu_active, bg_active, bg_owner, switch, conflict_cnt
    );

    modport slave (
        input  sched_en, lsu_req, lsu_bg, lsu_len,
        output lsu_gnt, lsu_active, bg_active, bg_owner, switch, conflict_cnt
    );

endinterface

// File: rtl/rr_arb4.sv
// 4-input round-robin arbiter: the first requester at or after ptr_i (wrapping) wins.
module rr_arb4
    import bg_lsu_xbar_sched_pkg::*;
(
    input  logic [N_PORT-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [N_PORT-1:0] gnt_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              any_o
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < N_PORT; off++) begin
            // 2-bit wraparound gives the modulo-4 rotation for free
            cand = ptr_i + SEL_W'(off);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bg_lsu_xbar_sched.sv
// Crossbar scheduler: per-BG round-robin grants, burst hold, and a switch value that is
// always a permutation of the four LSU indices.
module bg_lsu_xbar_sched
    import bg_lsu_xbar_sched_pkg::*;
#(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    bg_lsu_xbar_sched_if.slave bus
);

    bg_state_e         state_q [N_PORT];
    bg_state_e         state_d [N_PORT];
    logic [LEN_W-1:0]  cnt_q   [N_PORT];
    logic [LEN_W-1:0]  cnt_d   [N_PORT];
    logic [SEL_W-1:0]  ptr_q   [N_PORT];
    logic [SEL_W-1:0]  ptr_d   [N_PORT];
    logic [SEL_W-1:0]  owner_q [N_PORT];
    logic [SEL_W-1:0]  owner_d [N_PORT];

    logic [N_PORT-1:0]       gnt_q, gnt_d;
    logic [N_PORT-1:0]       act_q, act_d;
    logic [N_PORT*SEL_W-1:0] switch_q, switch_d;
    logic [CNT_W-1:0]        conf_q, conf_d;

    logic [N_PORT-1:0] elig    [N_PORT];
    logic [N_PORT-1:0] arb_gnt [N_PORT];
    logic [SEL_W-1:0]  arb_idx [N_PORT];
    logic [N_PORT-1:0] arb_any;
    logic              conflict;
    logic [N_PORT-1:0] used;
    logic              found;

    // elig[j][i]: LSU i may be granted BG j this cycle
    always_comb begin
        for (int unsigned j = 0; j < N_PORT; j++) begin
            elig[j] = '0;
            for (int unsigned i = 0; i < N_PORT; i++) begin
                elig[j][i] = bus.sched_en && bus.lsu_req[i] && !act_q[i] &&
                             (state_q[j] == IDLE) &&
                             (bus.lsu_bg[i*SEL_W +: SEL_W] == SEL_W'(j));
            end
        end
    end

    for (genvar g = 0; g < N_PORT; g++) begin : g_arb
        rr_arb4 u_arb (
            .req_i (elig[g]),
            .ptr_i (ptr_q[g]),
            .gnt_o (arb_gnt[g]),
            .idx_o (arb_idx[g]),
            .any_o (arb_any[g])
        );
    end

    always_comb begin
        gnt_d    = '0;
        act_d    = act_q;
        conflict = 1'b0;
        for (int unsigned j = 0; j < N_PORT; j++) begin
            state_d[j] = state_q[j];
            cnt_d[j]   = cnt_q[j];
            ptr_d[j]   = ptr_q[j];
            owner_d[j] = owner_q[j];
            if (state_q[j] == BUSY) begin
                if (cnt_q[j] == '0) begin
                    state_d[j]          = IDLE;
                    act_d[owner_q[j]]   = 1'b0;
                end else begin
                    cnt_d[j] = cnt_q[j] - LEN_W'(1);
                end
            end else if (arb_any[j]) begin
                state_d[j] = BUSY;
                owner_d[j] = arb_idx[j];
                cnt_d[j]   = bus.lsu_len[arb_idx[j]*LEN_W +: LEN_W];
                ptr_d[j]   = arb_idx[j] + SEL_W'(1);
                gnt_d      = gnt_d | arb_gnt[j];
                act_d      = act_d | arb_gnt[j];
            end
            if ($countones(elig[j]) > 1) begin
                conflict = 1'b1;
            end
        end
        conf_d = (conflict && (conf_q != '1)) ? conf_q + CNT_W'(1) : conf_q;
    end

    // Busy BGs keep their owner; idle BGs take the leftover LSUs in ascending order.
    always_comb begin
        used     = '0;
        switch_d = '0;
        found    = 1'b0;
        for (int unsigned j = 0; j < N_PORT; j++) begin
            if (state_d[j] == BUSY) begin
                used[owner_d[j]]               = 1'b1;
                switch_d[j*SEL_W +: SEL_W]     = owner_d[j];
            end
        end
        for (int unsigned j = 0; j < N_PORT; j++) begin
            if (state_d[j] == IDLE) begin
                found = 1'b0;
                for (int unsigned i = 0; i < N_PORT; i++) begin
                    if (!found && !used[i]) begin
                        found                      = 1'b1;
                        used[i]                    = 1'b1;
                        switch_d[j*SEL_W +: SEL_W] = SEL_W'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N_PORT; j++) begin
                state_q[j] <= IDLE;
                cnt_q[j]   <= '0;
                ptr_q[j]   <= '0;
                owner_q[j] <= '0;
            end
            gnt_q    <= '0;
            act_q    <= '0;
            switch_q <= SWITCH_IDENTITY;
            conf_q   <= '0;
        end else begin
            for (int unsigned j = 0; j < N_PORT; j++) begin
                state_q[j] <= state_d[j];
                cnt_q[j]   <= cnt_d[j];
                ptr_q[j]   <= ptr_d[j];
                owner_q[j] <= owner_d[j];
            end
            gnt_q    <= gnt_d;
            act_q    <= act_d;
            switch_q <= switch_d;
            conf_q   <= conf_d;
        end
    end

    logic [N_PORT-1:0]       bg_active;
    logic [N_PORT*SEL_W-1:0] bg_owner;

    always_comb begin
        bg_active = '0;
        bg_owner  = '0;
        for (int unsigned j = 0; j < N_PORT; j++) begin
            bg_active[j]               = (state_q[j] == BUSY);
            bg_owner[j*SEL_W +: SEL_W] = owner_q[j];
        end
    end

    assign bus.lsu_gnt      = gnt_q;
    assign bus.lsu_active   = act_q;
    assign bus.bg_active    = bg_active;
    assign bus.bg_owner     = bg_owner;
    assign bus.switch       = switch_q;
    assign bus.conflict_cnt = conf_q;

endmodule

// File: tb/tb_bg_lsu_xbar_sched.sv
// Bench for bg_lsu_xbar_sched: directed scenarios, a cycle-indexed reference model
// compared every cycle, and literal expectations at key points.
module tb_bg_lsu_xbar_sched;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bg_lsu_xbar_sched_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    bg_lsu_xbar_sched #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a BG granted at the edge ending cycle c is busy in cycles c+1 .. c+1+len.
    int         cyc     = 0;
    int         bend[4] = '{-1, -1, -1, -1};
    int         bown[4] = '{0, 0, 0, 0};
    int         mptr[4] = '{0, 0, 0, 0};
    logic [3:0] mgnt    = '0;
    int         mconf   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int  c, n, win, i;
        bit  act[4];
        bit  conf;
        logic [3:0] ng;
        c  = cyc;
        ng = '0;
        conf = 1'b0;
        for (int k = 0; k < 4; k++) act[k] = 1'b0;
        for (int j = 0; j < 4; j++) if (bend[j] >= c) act[bown[j]] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (bend[j] < c && bus.sched_en) begin
                n   = 0;
                win = -1;
                for (int k = 0; k < 4; k++) begin
                    i = (mptr[j] + k) % 4;
                    if (bus.lsu_req[i] && int'(bus.lsu_bg[2*i +: 2]) == j && !act[i]) begin
                        n++;
                        if (win < 0) win = i;
                    end
                end
                if (n >= 2) conf = 1'b1;
                if (win >= 0) begin
                    bown[j] = win;
                    bend[j] = c + 1 + int'(bus.lsu_len[4*win +: 4]);
                    mptr[j] = (win + 1) % 4;
                    ng[win] = 1'b1;
                end
            end
        end
        mgnt = ng;
        cyc  = c + 1;
        if (conf && mconf < 65535) mconf++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) begin
                bend[j] = -1;
                bown[j] = 0;
                mptr[j] = 0;
            end
            mgnt  = '0;
            mconf = 0;
        end else begin
            model_step();
        end
    end

    function automatic logic [3:0] exp_bg_active();
        logic [3:0] r = '0;
        for (int j = 0; j < 4; j++) r[j] = (bend[j] >= cyc);
        return r;
    endfunction

    function automatic logic [3:0] exp_lsu_active();
        logic [3:0] r = '0;
        for (int j = 0; j < 4; j++) if (bend[j] >= cyc) r[bown[j]] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] exp_owner_mask();
        logic [7:0] r = '0;
        for (int j = 0; j < 4; j++) if (bend[j] >= cyc) r[2*j +: 2] = 2'b11;
        return r;
    endfunction

    function automatic logic [7:0] exp_owner();
        logic [7:0] r = '0;
        for (int j = 0; j < 4; j++) if (bend[j] >= cyc) r[2*j +: 2] = 2'(bown[j]);
        return r;
    endfunction

    function automatic logic [7:0] exp_switch();
        logic [7:0] s = '0;
        bit used[4] = '{0, 0, 0, 0};
        for (int j = 0; j < 4; j++) begin
            if (bend[j] >= cyc) begin
                s[2*j +: 2]   = 2'(bown[j]);
                used[bown[j]] = 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (bend[j] < cyc) begin
                for (int i = 0; i < 4; i++) begin
                    if (!used[i]) begin
                        s[2*j +: 2] = 2'(i);
                        used[i]     = 1'b1;
                        break;
                    end
                end
            end
        end
        return s;
    endfunction

    initial forever begin
        @(negedge clk);
        chk("gnt", bus.lsu_gnt, mgnt);
        chk("lsu_active", bus.lsu_active, exp_lsu_active());
        chk("bg_active", bus.bg_active, exp_bg_active());
        chk("bg_owner", bus.bg_owner & exp_owner_mask(), exp_owner());
        chk("switch", bus.switch, exp_switch());
        chk("conflict_cnt", bus.conflict_cnt, mconf);
    end

    task automatic set_lsu(input int i, input bit r, input int bg, input int len);
        bus.lsu_req[i]         = r;
        bus.lsu_bg[2*i +: 2]   = 2'(bg);
        bus.lsu_len[4*i +: 4]  = 4'(len);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.sched_en = 1'b1;
        bus.lsu_req  = '0;
        bus.lsu_bg   = '0;
        bus.lsu_len  = '0;

        // Reset values, then release with no requests
        step(2);
        chk("rst_switch", bus.switch, 8'hE4);
        chk("rst_gnt", bus.lsu_gnt, 4'h0);
        chk("rst_active", {bus.lsu_active, bus.bg_active}, 8'h00);
        chk("rst_conf", bus.conflict_cnt, 0);
        chk("rst_owner", bus.bg_owner, 8'h00);
        rst_n = 1'b1;
        step(2);
        chk("idle_switch", bus.switch, 8'hE4);
        chk("idle_bg_active", bus.bg_active, 4'h0);

        // LSU2 -> BG1, len 3: four active cycles
        set_lsu(2, 1'b1, 1, 3);
        step(1);
        chk("single_gnt", bus.lsu_gnt, 4'b0100);
        chk("single_bg_active", bus.bg_active, 4'b0010);
        chk("single_switch", bus.switch, 8'hD8);
        chk("single_lsu_active", bus.lsu_active, 4'b0100);
        set_lsu(2, 1'b0, 1, 3);
        step(3);
        chk("single_last_beat", bus.bg_active, 4'b0010);
        step(1);
        chk("single_done", bus.bg_active, 4'b0000);
        chk("single_done_switch", bus.switch, 8'hE4);

        // LSU0/1/3 contend for BG0 with len 0
        set_lsu(0, 1'b1, 0, 0);
        set_lsu(1, 1'b1, 0, 0);
        set_lsu(3, 1'b1, 0, 0);
        step(1);
        chk("rr_gnt0", bus.lsu_gnt, 4'b0001);
        chk("rr_conf1", bus.conflict_cnt, 1);
        step(1);
        chk("rr_gap", bus.lsu_gnt, 4'b0000);
        step(1);
        chk("rr_gnt1", bus.lsu_gnt, 4'b0010);
        step(2);
        chk("rr_gnt3", bus.lsu_gnt, 4'b1000);
        step(2);
        chk("rr_gnt0_again", bus.lsu_gnt, 4'b0001);
        chk("rr_conf4", bus.conflict_cnt, 4);
        bus.lsu_req = '0;
        step(2);

        // All four LSUs to distinct BGs in the same cycle
        set_lsu(0, 1'b1, 3, 2);
        set_lsu(1, 1'b1, 2, 2);
        set_lsu(2, 1'b1, 1, 2);
        set_lsu(3, 1'b1, 0, 2);
        step(1);
        chk("x4_gnt", bus.lsu_gnt, 4'hF);
        chk("x4_switch", bus.switch, 8'h1B);
        chk("x4_bg_active", bus.bg_active, 4'hF);
        chk("x4_owner", bus.bg_owner, 8'h1B);
        bus.lsu_req = '0;
        step(3);
        chk("x4_done", bus.bg_active, 4'h0);

        // sched_en low while BG2 is busy and LSU1 waits for BG0
        set_lsu(3, 1'b1, 2, 5);
        step(1);
        chk("en_gnt3", bus.lsu_gnt, 4'b1000);
        set_lsu(3, 1'b0, 2, 5);
        bus.sched_en = 1'b0;
        set_lsu(1, 1'b1, 0, 1);
        step(5);
        chk("en_burst_last", bus.bg_active, 4'b0100);
        chk("en_hold_gnt", bus.lsu_gnt, 4'b0000);
        step(2);
        chk("en_idle", bus.bg_active, 4'b0000);
        chk("en_still_waiting", bus.lsu_active, 4'b0000);
        bus.sched_en = 1'b1;
        step(1);
        chk("en_gnt1", bus.lsu_gnt, 4'b0010);
        chk("en_bg0", bus.bg_active, 4'b0001);
        set_lsu(1, 1'b0, 0, 1);
        step(3);

        // Reset mid-burst; held requests re-arbitrate from pointer 0
        set_lsu(0, 1'b1, 1, 4);
        set_lsu(2, 1'b1, 1, 4);
        step(1);
        chk("mr_gnt0", bus.lsu_gnt, 4'b0001);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_active", {bus.lsu_active, bus.bg_active}, 8'h00);
        chk("mr_async_switch", bus.switch, 8'hE4);
        chk("mr_async_conf", bus.conflict_cnt, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("mr_regrant", bus.lsu_gnt, 4'b0001);
        chk("mr_owner", bus.bg_owner[3:2], 2'd0);
        chk("mr_switch", bus.switch, 8'hE1);
        bus.lsu_req = '0;
        step(8);

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
